sop_sweep_ctrl: RTL and testbench

SOP_SWEEP_CTRL -- requirements
Module: sop_sweep_ctrl

---
 rtl/sop_pkg.sv | 18 +
 rtl/sop_mismatch_log.sv | 63 ++++++
 rtl/sop_sweep_ctrl.sv | 134 +++++++++++++
 tb/tb_sop_sweep_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sop_pkg.sv
//------------------------------------------------------------------------------
// sop_pkg -- shared constants and FSM encoding for the SOP sweep controller
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sop_pkg;
  localparam int N_VEC = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = 6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
endpackage

`default_nettype wire

// File: rtl/sop_mismatch_log.sv
//------------------------------------------------------------------------------
// sop_mismatch_log -- counts mismatching vectors and records the lowest one
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sop_mismatch_log
  import sop_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sample_en,
  input  logic             mismatch,
  input  logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] fail_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             fail_valid
);

  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic [IDX_W-1:0] first_fail_idx_q, first_fail_idx_d;
  logic             fail_valid_q, fail_valid_d;

  always_comb begin
    fail_count_d     = fail_count_q;
    first_fail_idx_d = first_fail_idx_q;
    fail_valid_d     = fail_valid_q;
    if (clr) begin
      fail_count_d     = '0;
      first_fail_idx_d = '0;
      fail_valid_d     = 1'b0;
    end else if (sample_en && mismatch) begin
      // Saturate rather than wrap; 32 is the largest reachable count.
      if (fail_count_q != CNT_W'(N_VEC)) begin
        fail_count_d = fail_count_q + 1'b1;
      end
      if (!fail_valid_q) begin
        first_fail_idx_d = idx;
        fail_valid_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_count_q     <= '0;
      first_fail_idx_q <= '0;
      fail_valid_q     <= 1'b0;
    end else begin
      fail_count_q     <= fail_count_d;
      first_fail_idx_q <= first_fail_idx_d;
      fail_valid_q     <= fail_valid_d;
    end
  end

  assign fail_count     = fail_count_q;
  assign first_fail_idx = first_fail_idx_q;
  assign fail_valid     = fail_valid_q;

endmodule

`default_nettype wire

// File: rtl/sop_sweep_ctrl.sv
//------------------------------------------------------------------------------
// sop_sweep_ctrl -- exhaustive 32-vector sweep of a 5-input SOP block
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sop_sweep_ctrl
  import sop_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      expect_mask,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  input  logic             sop_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      truth,
  output logic [CNT_W-1:0] fail_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             fail_valid
);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       settle_q, settle_d;
  logic [31:0]      expect_q, expect_d;
  logic [31:0]      truth_q, truth_d;
  logic             pass_q, pass_d;
  logic             log_clr;
  logic             log_en;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    expect_d = expect_q;
    truth_d  = truth_q;
    pass_d   = pass_q;
    log_clr  = 1'b0;
    log_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_APPLY;
          idx_d    = '0;
          settle_d = '0;
          truth_d  = '0;
          pass_d   = 1'b0;
          expect_d = expect_mask;
          log_clr  = 1'b1;
        end
      end
      ST_APPLY: begin
        if (abort) begin
          state_d  = ST_IDLE;
          settle_d = '0;
        end else if (settle_q == 4'(SETTLE - 1)) begin
          state_d  = ST_SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          truth_d[idx_q] = sop_out;
          log_en         = 1'b1;
          if (idx_q == IDX_W'(N_VEC - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_APPLY;
          end
        end
      end
      default: begin
        pass_d  = (fail_count == '0);
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      expect_q <= '0;
      truth_q  <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      expect_q <= expect_d;
      truth_q  <= truth_d;
      pass_q   <= pass_d;
    end
  end

  sop_mismatch_log u_log (
    .clk            (clk),
    .rst            (rst),
    .clr            (log_clr),
    .sample_en      (log_en),
    .mismatch       (sop_out != expect_q[idx_q]),
    .idx            (idx_q),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx),
    .fail_valid     (fail_valid)
  );

  // Vector is only driven while a sweep is stepping; zero in IDLE and DONE.
  assign {a, b, c, d, e} = (state_q == ST_APPLY || state_q == ST_SAMPLE) ? idx_q : '0;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  // Pass becomes visible in the DONE cycle itself, then is held by pass_q.
  assign pass  = pass_q | (done && (fail_count == '0));
  assign truth = truth_q;

endmodule

`default_nettype wire

// File: tb/tb_sop_sweep_ctrl.sv
//------------------------------------------------------------------------------
// tb_sop_sweep_ctrl -- scoreboard bench for sop_sweep_ctrl (SETTLE=1 and 3)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sop_sweep_ctrl;

  typedef struct {
    int          done_cyc;
    logic [31:0] truth;
    logic [5:0]  fc;
    logic [4:0]  ffi;
    logic        fv;
    logic        pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, start, abort, start3;
  logic [31:0] expect_mask;
  logic [31:0] model_mask, flip_mask;

  logic        a, b, c, d, e, sop_out, busy, done, pass, fail_valid;
  logic [31:0] truth;
  logic [5:0]  fail_count;
  logic [4:0]  first_fail_idx;

  logic        a3, b3, c3, d3, e3, sop_out3, busy3, done3, pass3, fail_valid3;
  logic [31:0] truth3;
  logic [5:0]  fail_count3;
  logic [4:0]  first_fail_idx3;

  assign sop_out  = model_mask[{a, b, c, d, e}] ^ flip_mask[{a, b, c, d, e}];
  assign sop_out3 = model_mask[{a3, b3, c3, d3, e3}] ^ flip_mask[{a3, b3, c3, d3, e3}];

  sop_sweep_ctrl #(.SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expect_mask(expect_mask),
    .a(a), .b(b), .c(c), .d(d), .e(e), .sop_out(sop_out), .busy(busy), .done(done),
    .pass(pass), .truth(truth), .fail_count(fail_count),
    .first_fail_idx(first_fail_idx), .fail_valid(fail_valid)
  );

  sop_sweep_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(1'b0), .expect_mask(expect_mask),
    .a(a3), .b(b3), .c(c3), .d(d3), .e(e3), .sop_out(sop_out3), .busy(busy3), .done(done3),
    .pass(pass3), .truth(truth3), .fail_count(fail_count3),
    .first_fail_idx(first_fail_idx3), .fail_valid(fail_valid3)
  );

  int          sel = 0;
  logic [4:0]  cur_vec, cur_ffi;
  logic        cur_busy, cur_done, cur_pass, cur_fv;
  logic [31:0] cur_truth;
  logic [5:0]  cur_fc;

  always_comb begin
    cur_vec = {a, b, c, d, e}; cur_busy = busy; cur_done = done; cur_pass = pass;
    cur_fv = fail_valid; cur_truth = truth; cur_fc = fail_count; cur_ffi = first_fail_idx;
    if (sel != 0) begin
      cur_vec = {a3, b3, c3, d3, e3}; cur_busy = busy3; cur_done = done3; cur_pass = pass3;
      cur_fv = fail_valid3; cur_truth = truth3; cur_fc = fail_count3; cur_ffi = first_fail_idx3;
    end
  end

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic do_start(input bit push, input int s, output int t0);
    exp_t x;
    @(negedge clk);
    if (sel == 0) start = 1'b1; else start3 = 1'b1;
    t0 = cyc;
    if (push) begin
      x.done_cyc = t0 + 1 + 32 * (s + 1);
      x.truth    = model_mask ^ flip_mask;
      x.fc       = 6'($countones(flip_mask));
      x.ffi      = '0;
      for (int i = 31; i >= 0; i--) if (flip_mask[i]) x.ffi = 5'(i);
      x.fv       = (flip_mask != 0);
      x.pass     = (flip_mask == 0);
      sb.push_back(x);
    end
    @(negedge clk);
    start  = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic check_sweep(input int t0, input int s, input int poke);
    exp_t x;
    int   last = t0 + 1 + 32 * (s + 1) + 5;
    int   got = -1, ndone = 0, vbad = 0, n;
    while (cyc < last) begin
      n = cyc - t0;
      if (cur_done) begin ndone++; if (got < 0) got = cyc; end
      if (n >= 1 && n <= 32 * (s + 1)) begin
        if (cur_vec !== 5'((n - 1) / (s + 1)) || cur_busy !== 1'b1) vbad++;
      end else if (cur_vec !== 5'd0) vbad++;
      start = (poke >= 0 && n == poke);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL scoreboard_empty got 0 entries need 1");
      return;
    end
    x = sb.pop_front();
    checks++; if (ndone !== 1) begin errors++; $display("FAIL done_count got %0d need 1", ndone); end
    checks++; if (got !== x.done_cyc) begin errors++; $display("FAIL done_cycle got %0d need %0d", got - t0, x.done_cyc - t0); end
    checks++; if (vbad !== 0) begin errors++; $display("FAIL vector_hold got %0d bad cycles need 0", vbad); end
    checks++; if (cur_truth !== x.truth) begin errors++; $display("FAIL truth got %h need %h", cur_truth, x.truth); end
    checks++; if (cur_fc !== x.fc) begin errors++; $display("FAIL fail_count got %0d need %0d", cur_fc, x.fc); end
    checks++; if (cur_ffi !== x.ffi) begin errors++; $display("FAIL first_fail_idx got %0d need %0d", cur_ffi, x.ffi); end
    checks++; if (cur_fv !== x.fv) begin errors++; $display("FAIL fail_valid got %0b need %0b", cur_fv, x.fv); end
    checks++; if (cur_pass !== x.pass) begin errors++; $display("FAIL pass got %0b need %0b", cur_pass, x.pass); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start3 = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a, b, c, d, e, busy, done, pass, fail_valid} !== 9'd0) begin
      errors++; $display("FAIL reset_ctrl got %b need 0", {a, b, c, d, e, busy, done, pass, fail_valid});
    end
    checks++;
    if ({truth, fail_count, first_fail_idx} !== 43'd0) begin
      errors++; $display("FAIL reset_data got %h need 0", {truth, fail_count, first_fail_idx});
    end
  endtask

  task automatic test_sweep(input logic [31:0] flip);
    int t0;
    flip_mask = flip;
    do_start(1'b1, 1, t0);
    check_sweep(t0, 1, -1);
  endtask

  task automatic test_abort();
    int t0, nd = 0;
    flip_mask = '0;
    do_start(1'b0, 1, t0);
    while (cyc < t0 + 10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || {a, b, c, d, e} !== 5'd0) begin
      errors++; $display("FAIL abort_idle got busy=%b vec=%0d need 0 0", busy, {a, b, c, d, e});
    end
    repeat (100) begin if (done) nd++; @(negedge clk); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_done got %0d pulses need 0", nd); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL abort_pass got %b need 0", pass); end
  endtask

  task automatic test_start_abort_together();
    int nb = 0;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (3) begin if (busy) nb++; @(negedge clk); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL start_abort got busy %0d cycles need 0", nb); end
  endtask

  task automatic test_back_to_back();
    int t0;
    flip_mask = '0;
    do_start(1'b1, 1, t0);
    check_sweep(t0, 1, 20);
  endtask

  task automatic test_reset_midsweep();
    int t0;
    flip_mask = 32'h0000_0001;
    do_start(1'b0, 1, t0);
    while (cyc < t0 + 30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a, b, c, d, e, busy, done, pass, fail_valid} !== 9'd0 ||
        {truth, fail_count, first_fail_idx} !== 43'd0) begin
      errors++; $display("FAIL mid_reset got busy=%b truth=%h fc=%0d need all 0", busy, truth, fail_count);
    end
    flip_mask = '0;
    do_start(1'b1, 1, t0);
    check_sweep(t0, 1, -1);
  endtask

  task automatic test_settle3();
    int t0;
    sel = 1;
    flip_mask = '0;
    do_start(1'b1, 3, t0);
    check_sweep(t0, 3, -1);
    sel = 0;
  endtask

  initial begin
    model_mask  = 32'hA5A5_0F0F;
    expect_mask = 32'hA5A5_0F0F;
    flip_mask   = '0;
    test_reset();
    test_sweep(32'h0000_0000);
    test_sweep(32'h0002_0008);
    test_abort();
    test_start_abort_together();
    test_back_to_back();
    test_reset_midsweep();
    test_settle3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout need completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
